// File: rtl/dmem_responder_if.sv
// M-stage <-> data-memory handshake bundle: request fields from the CPU,
// completion/stall/read-data back from the responder.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, stall, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, stall, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word data memory for the pipelined CPU M stage: IDLE->BUSY->DONE
// with WAIT_CYCLES wait states. Define DMEM_ERR_CHECK_EN for misaligned/out-of-range faults.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx;
  logic            we_q;
  logic [31:0]     wdata_q;
  logic            fault_q;
  logic [31:0]     rdata_q;
  logic            ready_q;
  logic            err_q;
  logic            fault;
  logic [31:0]     mem [DEPTH];

`ifdef DMEM_ERR_CHECK_EN
  assign fault = (bus.addr[1:0] != 2'b00) || (bus.addr[31:AW+2] != '0);
`else
  logic unused_addr_bits;
  assign fault            = 1'b0;
  assign unused_addr_bits = ^{bus.addr[1:0], bus.addr[31:AW+2]};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            idx     <= bus.addr[AW+1:2];
            we_q    <= bus.we;
            wdata_q <= bus.wdata;
            fault_q <= fault;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!we_q) rdata_q <= fault_q ? 32'd0 : mem[idx];
            err_q   <= err_q | fault_q;
            ready_q <= 1'b1;
            state   <= DONE;
          end
        end
        // A req still high here belongs to the finished instruction.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is never reset; an aborted store never reaches its completion edge.
  always_ff @(posedge clk) begin
    if (state == BUSY && cnt == 4'd0 && we_q && !fault_q)
      mem[idx] <= wdata_q;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.stall = rst && ((state == IDLE) ? bus.req : (state == BUSY));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2 main instance,
// WAIT_CYCLES=0 second instance); honours DMEM_ERR_CHECK_EN if defined.
module tb_dmem_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One complete access on the main instance; req drops on the ready cycle.
  task automatic applyStimulus(input string tag, input logic w, input logic [31:0] a,
                               input logic [31:0] d, output int stall_cnt,
                               output logic [31:0] rd, output logic e);
    logic timed_out;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    stall_cnt = 0;
    timed_out = 1'b0;
    for (int c = 0; ; c++) begin
      #1;
      if (bus.ready === 1'b1) break;
      if (bus.stall === 1'b1) stall_cnt++;
      if (c > 40) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rd = bus.rdata;
    e  = bus.err;
    checkOutput({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
    checkOutput({tag, "_stall_in_done"}, {31'd0, bus.stall}, 32'd0);
    bus.req = 1'b0;
  endtask

  int          sc;
  logic [31:0] rd;
  logic        e;
  int          pulses;
  int          first_c;
  int          second_c;
  logic [31:0] rd1;
  logic [31:0] rd2;

  initial begin
    checks    = 0;
    errors    = 0;
    bus.req   = 1'b1;
    bus.we    = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    bus0.req  = 1'b0;
    bus0.we   = 1'b0;
    bus0.addr = 32'h0;
    bus0.wdata = 32'h0;
    rst = 1'b0;

    // Reset held with req high: everything quiet, stall forced low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_stall", {31'd0, bus.stall}, 32'd0);
      checkOutput("rst_ready", {31'd0, bus.ready}, 32'd0);
      checkOutput("rst_rdata", bus.rdata, 32'd0);
      checkOutput("rst_err",   {31'd0, bus.err},   32'd0);
    end
    bus.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Store then load the same word.
    applyStimulus("st10", 1'b1, 32'h10, 32'hDEADBEEF, sc, rd, e);
    checkOutput("st10_stall_cycles", sc, 32'd4);
    checkOutput("st10_rdata_kept", rd, 32'd0);
    applyStimulus("ld10", 1'b0, 32'h10, 32'h0, sc, rd, e);
    checkOutput("ld10_stall_cycles", sc, 32'd4);
    checkOutput("ld10_rdata", rd, 32'hDEADBEEF);
    checkOutput("ld10_err", {31'd0, e}, 32'd0);

    applyStimulus("st14", 1'b1, 32'h14, 32'h12345678, sc, rd, e);
    checkOutput("st14_rdata_kept", rd, 32'hDEADBEEF);

    // Back-to-back loads with req held through DONE.
    @(negedge clk);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'h10;
    pulses   = 0;
    first_c  = -1;
    second_c = -1;
    rd1 = '0;
    rd2 = '0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (bus.ready === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          first_c  = c;
          rd1      = bus.rdata;
          bus.addr = 32'h14;
        end else if (pulses == 2) begin
          second_c = c;
          rd2      = bus.rdata;
          bus.req  = 1'b0;
        end
      end
      @(negedge clk);
    end
    checkOutput("b2b_pulses", pulses, 32'd2);
    checkOutput("b2b_first_cycle", first_c, 32'd4);
    checkOutput("b2b_gap", second_c - first_c, 32'd5);
    checkOutput("b2b_rdata1", rd1, 32'hDEADBEEF);
    checkOutput("b2b_rdata2", rd2, 32'h12345678);

    // Reset in the middle of a store: the word keeps its old value.
    applyStimulus("st20_prior", 1'b1, 32'h20, 32'h0BADF00D, sc, rd, e);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h20;
    bus.wdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("abort_busy_stall", {31'd0, bus.stall}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("abort_stall_drop", {31'd0, bus.stall}, 32'd0);
    checkOutput("abort_rdata", bus.rdata, 32'd0);
    bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus("ld20", 1'b0, 32'h20, 32'h0, sc, rd, e);
    checkOutput("ld20_rdata", rd, 32'h0BADF00D);

`ifdef DMEM_ERR_CHECK_EN
    applyStimulus("st0", 1'b1, 32'h0, 32'h00000055, sc, rd, e);
    applyStimulus("ld_mis", 1'b0, 32'h2, 32'h0, sc, rd, e);
    checkOutput("ld_mis_stall_cycles", sc, 32'd4);
    checkOutput("ld_mis_rdata", rd, 32'd0);
    checkOutput("ld_mis_err", {31'd0, e}, 32'd1);
    applyStimulus("st_oob", 1'b1, 32'h1000, 32'h00000099, sc, rd, e);
    checkOutput("st_oob_err_sticky", {31'd0, e}, 32'd1);
    applyStimulus("ld0", 1'b0, 32'h0, 32'h0, sc, rd, e);
    checkOutput("ld0_rdata", rd, 32'h00000055);
    checkOutput("ld0_err_sticky", {31'd0, e}, 32'd1);
`else
    applyStimulus("st_wrap", 1'b1, 32'h1000, 32'h000000AA, sc, rd, e);
    applyStimulus("ld0", 1'b0, 32'h0, 32'h0, sc, rd, e);
    checkOutput("ld0_wrap_rdata", rd, 32'h000000AA);
    checkOutput("ld0_err", {31'd0, e}, 32'd0);
`endif

    // Zero wait states on the second instance.
    @(negedge clk);
    bus0.req  = 1'b1;
    bus0.we   = 1'b0;
    bus0.addr = 32'h10;
    sc       = 0;
    first_c  = -1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus0.stall === 1'b1) sc++;
      if (bus0.ready === 1'b1 && first_c < 0) begin
        first_c  = c;
        bus0.req = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("w0_stall_cycles", sc, 32'd2);
    checkOutput("w0_ready_cycle", first_c, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
